// File: rtl/main_fsm_decoder.sv
// rtl/main_fsm_decoder.sv - multicycle control FSM with instruction decode
// Optional memory-wait timeout enabled by defining MEM_TIMEOUT_EN.
module main_fsm_decoder #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int STATE_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               MemWR,
    output logic               RegWR,
    output logic               Branch,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic               ALUOp,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         InmSrc,
    output logic [1:0]         RegSrc,
    output logic               fault,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_FAULT  = 4'd10
    } state_t;

    state_t state_q, state_d;

    logic bit_i, bit_l;
    logic unused_funct;

    assign bit_i        = Funct[5];
    assign bit_l        = Funct[0];
    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       in_wait;
    logic       timeout;

    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // A ready on the last allowed cycle still completes, so only a stalled final cycle faults.
    assign timeout = in_wait && !mem_ready && (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = 8'd0;
        end else if (in_wait && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'd0:    state_d = bit_i ? S_EXECI : S_EXECR;
                    2'd1:    state_d = S_MEMADR;
                    2'd2:    state_d = S_BRANCH;
                    default: state_d = S_FAULT;
                endcase
            end
            S_MEMADR: state_d = bit_l ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_MEMWB,
            S_ALUWB,
            S_BRANCH: state_d = S_FETCH;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase
`ifdef MEM_TIMEOUT_EN
        if (timeout) begin
            state_d = S_FAULT;
        end
`endif
    end

    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        MemWR     = 1'b0;
        RegWR     = 1'b0;
        Branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUOp     = 1'b0;
        ALUSrcB   = 2'd0;
        ResultSrc = 2'd0;
        fault     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
                // Fetch completes in the ready cycle; reset suppresses the write strobe.
                PCWrite   = mem_ready && !reset;
                IRWrite   = mem_ready && !reset;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
            end
            S_MEMADR: ALUSrcB = 2'd1;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'd1;
                RegWR     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemWR  = 1'b1;
            end
            S_EXECR:  ALUOp = 1'b1;
            S_EXECI: begin
                ALUSrcB = 2'd1;
                ALUOp   = 1'b1;
            end
            S_ALUWB:  RegWR = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'd1;
                ResultSrc = 2'd2;
                Branch    = 1'b1;
            end
            S_FAULT:  fault = 1'b1;
            default:  fault = 1'b1;
        endcase
    end

    always_comb begin
        InmSrc = 2'd0;
        RegSrc = 2'd0;
        case (Op)
            2'd1: begin
                InmSrc = 2'd1;
                RegSrc = bit_l ? 2'd0 : 2'd2;
            end
            2'd2: begin
                InmSrc = 2'd2;
                RegSrc = 2'd1;
            end
            default: begin
                InmSrc = 2'd0;
                RegSrc = 2'd0;
            end
        endcase
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_main_fsm_decoder.sv
// tb/tb_main_fsm_decoder.sv - self-checking bench for main_fsm_decoder
module tb_main_fsm_decoder;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       PCWrite, IRWrite, MemWR, RegWR, Branch, AdrSrc, ALUSrcA, ALUOp;
    logic [1:0] ALUSrcB, ResultSrc, InmSrc, RegSrc;
    logic       fault;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    main_fsm_decoder #(.TIMEOUT_CYCLES(TO), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWR(MemWR), .RegWR(RegWR),
        .Branch(Branch), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .InmSrc(InmSrc), .RegSrc(RegSrc),
        .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    logic [16:0] ctl_act;
    assign ctl_act = {PCWrite, IRWrite, MemWR, RegWR, Branch, AdrSrc, ALUSrcA, ALUOp,
                      ALUSrcB, ResultSrc, InmSrc, RegSrc, fault};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    function automatic logic is_wait(input logic [3:0] s);
        return (s == 4'd0) || (s == 4'd3) || (s == 4'd5);
    endfunction

    // Reference next state straight from the transition rules
    function automatic logic [3:0] m_next(input logic [3:0] s, input logic [1:0] op,
                                          input logic [5:0] f, input logic mr);
        logic [3:0] dec_tbl [4];
        dec_tbl[0] = f[5] ? 4'd7 : 4'd6;
        dec_tbl[1] = 4'd2;
        dec_tbl[2] = 4'd9;
        dec_tbl[3] = 4'd10;
        case (s)
            4'd0:          return mr ? 4'd1 : 4'd0;
            4'd1:          return dec_tbl[op];
            4'd2:          return f[0] ? 4'd3 : 4'd5;
            4'd3:          return mr ? 4'd4 : 4'd3;
            4'd5:          return mr ? 4'd0 : 4'd5;
            4'd6, 4'd7:    return 4'd8;
            4'd4, 4'd8, 4'd9: return 4'd0;
            default:       return 4'd10;
        endcase
    endfunction

    function automatic logic [16:0] m_ctl(input logic [3:0] s, input logic [1:0] op,
                                          input logic [5:0] f, input logic mr, input logic rst);
        logic pcw, irw, mw, rw, br, adr, asa, aop, flt;
        logic [1:0] asb, rs, ims, rgs;
        {pcw, irw, mw, rw, br, adr, asa, aop, flt} = '0;
        asb = 0; rs = 0; ims = 0; rgs = 0;
        case (s)
            4'd0: begin asa = 1; asb = 2; rs = 2; pcw = mr & ~rst; irw = mr & ~rst; end
            4'd1: begin asa = 1; asb = 2; rs = 2; end
            4'd2: asb = 1;
            4'd3: adr = 1;
            4'd4: begin rs = 1; rw = 1; end
            4'd5: begin adr = 1; mw = 1; end
            4'd6: aop = 1;
            4'd7: begin asb = 1; aop = 1; end
            4'd8: rw = 1;
            4'd9: begin asb = 1; rs = 2; br = 1; end
            default: flt = 1;
        endcase
        if (op == 2'd1) begin ims = 1; rgs = f[0] ? 2'd0 : 2'd2; end
        if (op == 2'd2) begin ims = 2; rgs = 1; end
        return {pcw, irw, mw, rw, br, adr, asa, aop, asb, rs, ims, rgs, flt};
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  stall_st;
        int          stall_n;
        int          len;
        logic [39:0] seq;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [3:0] ms;
        int         mzeros;
        logic [3:0] exp_st;
        logic [3:0] nxt;
        int         stalls;
        int         k;
        logic [1:0] e_ims, e_rgs;

        vecs[0] = '{2'd0, 6'h00, 4'd15, 0, 5, 40'h0168000000};
        vecs[1] = '{2'd0, 6'h20, 4'd15, 0, 5, 40'h0178000000};
        vecs[2] = '{2'd1, 6'h01, 4'd3,  3, 9, 40'h0123333400};
        vecs[3] = '{2'd1, 6'h00, 4'd15, 0, 5, 40'h0125000000};
        vecs[4] = '{2'd2, 6'h00, 4'd15, 0, 4, 40'h0190000000};
        vecs[5] = '{2'd0, 6'h3e, 4'd0,  2, 7, 40'h0001780000};
        vecs[6] = '{2'd1, 6'h1e, 4'd5,  2, 7, 40'h0125550000};

        reset = 1'b1; Op = 2'd0; Funct = 6'd0; mem_ready = 1'b1;
        #1;
        chk("reset_state", state, 4'd0);
        chk("reset_ctl", ctl_act, m_ctl(4'd0, 2'd0, 6'd0, 1'b1, 1'b1));
        cyc();
        reset = 1'b0;

        foreach (vecs[v]) begin
            do_reset();
            Op = vecs[v].op;
            Funct = vecs[v].funct;
            stalls = 0;
            e_ims = (Op == 2'd1) ? 2'd1 : (Op == 2'd2) ? 2'd2 : 2'd0;
            e_rgs = (Op == 2'd1) ? (Funct[0] ? 2'd0 : 2'd2) : (Op == 2'd2) ? 2'd1 : 2'd0;
            for (int i = 0; i < vecs[v].len; i++) begin
                exp_st = vecs[v].seq[39 - 4*i -: 4];
                mem_ready = !(exp_st == vecs[v].stall_st && stalls < vecs[v].stall_n);
                if (!mem_ready) stalls++;
                @(negedge clk);
                chk($sformatf("vec%0d_state%0d", v, i), state, exp_st);
                chk($sformatf("vec%0d_regwr%0d", v, i), RegWR, (exp_st == 4'd4 || exp_st == 4'd8));
                chk($sformatf("vec%0d_memwr%0d", v, i), MemWR, exp_st == 4'd5);
                chk($sformatf("vec%0d_inm_regsrc%0d", v, i), {InmSrc, RegSrc}, {e_ims, e_rgs});
                cyc();
            end
        end

        // Reset asserted mid-MEMRD, then FETCH resumes on the first edge after release
        do_reset();
        Op = 2'd1; Funct = 6'h01; mem_ready = 1'b1;
        k = 0;
        while (state != 4'd3 && k < 10) begin
            cyc();
            k++;
        end
        chk("reach_memrd", state, 4'd3);
        mem_ready = 1'b0;
        cyc();
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_state", state, 4'd0);
        chk("async_reset_wr", {RegWR, PCWrite, MemWR}, 3'b000);
        cyc();
        reset = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_fetch", state, 4'd0);
        chk("post_reset_regwr", RegWR, 1'b0);
        cyc();
        chk("post_reset_decode", state, 4'd1);

        // Undefined op traps in FAULT regardless of inputs
        do_reset();
        Op = 2'd3; mem_ready = 1'b1;
        cyc();
        cyc();
        for (int i = 0; i < 20; i++) begin
            Op = 2'($urandom);
            Funct = 6'($urandom);
            mem_ready = 1'($urandom);
            @(negedge clk);
            chk($sformatf("fault_hold%0d", i), {state, fault, PCWrite, RegWR, MemWR, IRWrite},
                {4'd10, 1'b1, 4'b0000});
            cyc();
        end

`ifdef MEM_TIMEOUT_EN
        do_reset();
        mem_ready = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            cyc();
            chk($sformatf("timeout_step%0d", i), state, (i == TO) ? 4'd10 : 4'd0);
        end
        mem_ready = 1'b1;
        cyc();
        cyc();
        chk("timeout_sticky", {state, fault}, {4'd10, 1'b1});
        do_reset();
        mem_ready = 1'b0;
        for (int i = 1; i < TO; i++) cyc();
        mem_ready = 1'b1;
        cyc();
        chk("ready_last_cycle_wins", state, 4'd1);
`else
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 40; i++) cyc();
        chk("wait_holds", {state, fault}, {4'd0, 1'b0});
        mem_ready = 1'b1;
        cyc();
        chk("wait_released", state, 4'd1);
`endif

        // Randomized run against the reference model
        do_reset();
        ms = 4'd0;
        mzeros = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom % 16);
            reset = ($urandom % 40) == 0;
            Op = (r == 0) ? 2'd3 : 2'(r % 3);
            Funct = 6'($urandom);
            mem_ready = ($urandom % 4) != 0;
            if (reset) begin
                ms = 4'd0;
                mzeros = 0;
            end
            @(negedge clk);
            chk($sformatf("rnd%0d", c), {state, 4'd0, ctl_act}, {ms, 4'd0, m_ctl(ms, Op, Funct, mem_ready, reset)});
            if (!reset) begin
                nxt = m_next(ms, Op, Funct, mem_ready);
`ifdef MEM_TIMEOUT_EN
                if (is_wait(ms) && !mem_ready && (mzeros + 1) >= TO) nxt = 4'd10;
                if (nxt != ms) mzeros = 0;
                else if (is_wait(ms) && !mem_ready) mzeros++;
`else
                mzeros = is_wait(ms) ? mzeros : 0;
`endif
                ms = nxt;
            end
            cyc();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
